// File: rtl/npu_core_param.sv
// Parametrised NPU compute core: signed MAC over LEN beats, bias, requantise, output FIFO.
// Optional feature macro: NPU_RELU_EN (clamp negative shifted results to zero).
module npu_core_param #(
  parameter int DATA_W      = 8,
  parameter int NUM_LANES   = 4,
  parameter int NUM_NEURONS = 2,
  parameter int BIAS_W      = 16,
  parameter int LEN_W       = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                      CLKEXT,
  input  logic                                      RST_GLO,
  input  logic                                      START,
  input  logic [LEN_W-1:0]                          LEN,
  input  logic [3:0]                                SHIFT,
  input  logic [NUM_NEURONS*NUM_LANES*DATA_W-1:0]   W_IN,
  input  logic [NUM_NEURONS*BIAS_W-1:0]             BIAS_IN,
  input  logic [NUM_LANES*DATA_W-1:0]               D_IN,
  input  logic                                      D_VALID,
  output logic                                      D_READY,
  input  logic                                      RD_EN,
  output logic [DATA_W-1:0]                         D_OUT,
  output logic                                      FIFO_FULL,
  output logic                                      FIFO_EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]               FIFO_COUNT,
  output logic                                      BUSY,
  output logic                                      DONE
);

  localparam int ACC_W = 2*DATA_W + $clog2(NUM_LANES) + LEN_W;
  localparam int SUM_W = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [3:0] shift_q, shift_d;
  logic [NUM_NEURONS*NUM_LANES*DATA_W-1:0] w_q, w_d;
  logic [NUM_NEURONS*BIAS_W-1:0] bias_q, bias_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q [NUM_NEURONS];
  logic signed [ACC_W-1:0] acc_d [NUM_NEURONS];
  logic signed [ACC_W-1:0] mac [NUM_NEURONS];

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic push, pop, fifo_full, fifo_empty;
  logic signed [ACC_W-1:0] sel_acc;
  logic signed [BIAS_W-1:0] sel_bias;
  logic signed [SUM_W-1:0] sum, shifted;
  logic [DATA_W-1:0] result;

  // Per-beat dot product of the lane data with each neuron's latched weight row.
  always_comb begin
    logic signed [ACC_W-1:0] a_ext, b_ext;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      mac[n] = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        a_ext = {{(ACC_W-DATA_W){D_IN[l*DATA_W+DATA_W-1]}}, D_IN[l*DATA_W +: DATA_W]};
        b_ext = {{(ACC_W-DATA_W){w_q[(n*NUM_LANES+l)*DATA_W+DATA_W-1]}},
                 w_q[(n*NUM_LANES+l)*DATA_W +: DATA_W]};
        mac[n] = mac[n] + a_ext * b_ext;
      end
    end
  end

  always_comb begin
    sel_acc  = acc_q[0];
    sel_bias = bias_q[BIAS_W-1:0];
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (idx_q == IDX_W'(n)) begin
        sel_acc  = acc_q[n];
        sel_bias = bias_q[n*BIAS_W +: BIAS_W];
      end
    end
    sum = {{(SUM_W-ACC_W){sel_acc[ACC_W-1]}}, sel_acc}
        + {{(SUM_W-BIAS_W){sel_bias[BIAS_W-1]}}, sel_bias};
    shifted = sum >>> shift_q;
`ifdef NPU_RELU_EN
    if (shifted[SUM_W-1]) shifted = '0;
`endif
    // Out of range when the bits above the output sign bit are not a pure sign extension.
    if (!((&shifted[SUM_W-1:DATA_W-1]) || !(|shifted[SUM_W-1:DATA_W-1])))
      result = shifted[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      result = shifted[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    shift_d = shift_q;
    w_d     = w_q;
    bias_d  = bias_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          len_d   = LEN;
          shift_d = SHIFT;
          w_d     = W_IN;
          bias_d  = BIAS_IN;
          beat_d  = '0;
          idx_d   = '0;
          for (int n = 0; n < NUM_NEURONS; n++) acc_d[n] = '0;
          state_d = (LEN != '0) ? S_ACCUM : S_WRITE;
        end
      end
      S_ACCUM: begin
        if (D_VALID) begin
          for (int n = 0; n < NUM_NEURONS; n++) acc_d[n] = acc_q[n] + mac[n];
          beat_d = beat_q + LEN_W'(1);
          if (beat_q == len_q - LEN_W'(1)) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!fifo_full) begin
          push  = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_NEURONS-1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output FIFO: push from the WRITE state, pop on RD_EN into the registered D_OUT.
  always_comb begin
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    pop        = RD_EN && !fifo_empty;
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dout_d     = dout_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = result;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      dout_d   = fifo_mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      beat_q   <= '0;
      shift_q  <= '0;
      w_q      <= '0;
      bias_q   <= '0;
      idx_q    <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      shift_q  <= shift_d;
      w_q      <= w_d;
      bias_q   <= bias_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge CLKEXT) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign D_READY    = (state_q == S_ACCUM);
  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = (state_q == S_DONE);
  assign D_OUT      = dout_q;
  assign FIFO_FULL  = fifo_full;
  assign FIFO_EMPTY = fifo_empty;
  assign FIFO_COUNT = count_q;

endmodule

// File: tb/tb_npu_core_param.sv
// Directed self-checking bench for npu_core_param (default parameters).
// Expected values follow NPU_RELU_EN when the macro is defined for the build.
module tb_npu_core_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [3:0]  shift = '0;
  logic [63:0] w_in = '0;
  logic [31:0] bias_in = '0;
  logic [31:0] d_in = '0;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic        rd_en = 1'b0;
  logic [7:0]  d_out;
  logic        fifo_full, fifo_empty;
  logic [3:0]  fifo_count;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  npu_core_param dut (
    .CLKEXT(clk), .RST_GLO(rst), .START(start), .LEN(len), .SHIFT(shift),
    .W_IN(w_in), .BIAS_IN(bias_in), .D_IN(d_in), .D_VALID(d_valid),
    .D_READY(d_ready), .RD_EN(rd_en), .D_OUT(d_out), .FIFO_FULL(fifo_full),
    .FIFO_EMPTY(fifo_empty), .FIFO_COUNT(fifo_count), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; d_valid = 1'b0; rd_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic set_job(input logic [7:0] l, input logic [3:0] s,
                         input logic [7:0] w0, input logic [7:0] w1,
                         input logic [15:0] b0, input logic [15:0] b1);
    len = l;
    shift = s;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++)
        w_in[(n*4+k)*8 +: 8] = (n == 0) ? w0 : w1;
    bias_in = {b1, b0};
  endtask

  task automatic start_job(input logic [7:0] l, input logic [3:0] s,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input logic [15:0] b0, input logic [15:0] b1);
    set_job(l, s, w0, w1, b0, b1);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pop(output logic [7:0] v);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    v = d_out;
  endtask

  task automatic wait_done(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, d_ready, fifo_full, fifo_empty} !== 5'b00001) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=00001", {busy, done, d_ready, fifo_full, fifo_empty});
    end
    checks++;
    if (fifo_count !== 4'd0 || d_out !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_count_dout got=%0d/%0d exp=0/0", fifo_count, d_out);
    end
  endtask

  task automatic test_basic();
    logic [7:0] v;
    do_reset();
    start_job(8'd1, 4'd0, 8'd1, 8'd2, 16'd0, 16'd5);
    checks++;
    if (busy !== 1'b1 || d_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_accum got busy=%b ready=%b exp 1/1", busy, d_ready);
    end
    d_in = {8'd4, 8'd3, 8'd2, 8'd1};
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    tick();
    checks++;
    if (fifo_count !== 4'd1) begin
      failures++;
      $display("[TB] FAIL basic_first_push got=%0d exp=1", fifo_count);
    end
    tick();
    checks++;
    if (done !== 1'b1 || fifo_count !== 4'd2) begin
      failures++;
      $display("[TB] FAIL basic_done got done=%b count=%0d exp 1/2", done, fifo_count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_idle got done=%b busy=%b exp 0/0", done, busy);
    end
    pop(v);
    checks++;
    if ($signed(v) !== 10) begin
      failures++;
      $display("[TB] FAIL basic_r0 got=%0d exp=10", $signed(v));
    end
    pop(v);
    checks++;
    if ($signed(v) !== 25 || fifo_empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_r1 got=%0d empty=%b exp=25/1", $signed(v), fifo_empty);
    end
  endtask

  task automatic test_saturate_shift();
    logic [7:0] v;
    bit seen;
    int exp_neg_sat, exp_neg_shift;
`ifdef NPU_RELU_EN
    exp_neg_sat = 0;  exp_neg_shift = 0;
`else
    exp_neg_sat = -128; exp_neg_shift = -7;
`endif
    do_reset();
    start_job(8'd4, 4'd0, 8'd127, 8'h80, 16'd0, 16'd0);
    d_in = 32'h7f7f7f7f;
    d_valid = 1'b1;
    repeat (4) tick();
    d_valid = 1'b0;
    wait_done(10, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL sat_done got=0 exp=1");
    end
    tick();
    pop(v);
    checks++;
    if ($signed(v) !== 127) begin
      failures++;
      $display("[TB] FAIL sat_pos got=%0d exp=127", $signed(v));
    end
    pop(v);
    checks++;
    if ($signed(v) !== exp_neg_sat) begin
      failures++;
      $display("[TB] FAIL sat_neg got=%0d exp=%0d", $signed(v), exp_neg_sat);
    end
    // acc = +/-100, shifted right by 4 with floor rounding
    start_job(8'd1, 4'd4, 8'd1, 8'hff, 16'd0, 16'd0);
    d_in = 32'h19191919;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    wait_done(10, seen);
    tick();
    pop(v);
    checks++;
    if ($signed(v) !== 6) begin
      failures++;
      $display("[TB] FAIL shift_pos got=%0d exp=6", $signed(v));
    end
    pop(v);
    checks++;
    if ($signed(v) !== exp_neg_shift) begin
      failures++;
      $display("[TB] FAIL shift_neg got=%0d exp=%0d", $signed(v), exp_neg_shift);
    end
  endtask

  task automatic test_len_zero();
    logic [7:0] v;
    bit seen, saw_ready;
    int exp_b1;
`ifdef NPU_RELU_EN
    exp_b1 = 0;
`else
    exp_b1 = -4;
`endif
    do_reset();
    start_job(8'd0, 4'd0, 8'd0, 8'd0, 16'd3, 16'hfffc);
    seen = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (d_ready) saw_ready = 1'b1;
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || saw_ready) begin
      failures++;
      $display("[TB] FAIL len0_flow got done=%b ready_seen=%b exp 1/0", seen, saw_ready);
    end
    tick();
    pop(v);
    checks++;
    if ($signed(v) !== 3) begin
      failures++;
      $display("[TB] FAIL len0_r0 got=%0d exp=3", $signed(v));
    end
    pop(v);
    checks++;
    if ($signed(v) !== exp_b1) begin
      failures++;
      $display("[TB] FAIL len0_r1 got=%0d exp=%0d", $signed(v), exp_b1);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] v;
    bit seen, any_done;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      start_job(8'd0, 4'd0, 8'd0, 8'd0, 16'(10 + 2*j), 16'(11 + 2*j));
      wait_done(10, seen);
      checks++;
      if (!seen) begin
        failures++;
        $display("[TB] FAIL full_job%0d_done got=0 exp=1", j);
      end
      tick();
    end
    checks++;
    if (fifo_full !== 1'b1 || fifo_count !== 4'd8) begin
      failures++;
      $display("[TB] FAIL full_flag got full=%b count=%0d exp 1/8", fifo_full, fifo_count);
    end
    start_job(8'd0, 4'd0, 8'd0, 8'd0, 16'd18, 16'd19);
    any_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) any_done = 1'b1;
    end
    checks++;
    if (busy !== 1'b1 || any_done || fifo_count !== 4'd8) begin
      failures++;
      $display("[TB] FAIL full_stall got busy=%b done_seen=%b count=%0d exp 1/0/8", busy, any_done, fifo_count);
    end
    pop(v);
    checks++;
    if ($signed(v) !== 10 || fifo_count !== 4'd7) begin
      failures++;
      $display("[TB] FAIL full_pop1 got=%0d count=%0d exp=10/7", $signed(v), fifo_count);
    end
    tick();
    checks++;
    if (fifo_count !== 4'd8 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_push1 got count=%0d done=%b busy=%b exp 8/0/1", fifo_count, done, busy);
    end
    pop(v);
    tick();
    checks++;
    if ($signed(v) !== 11 || done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_pop2 got=%0d done=%b exp=11/1", $signed(v), done);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      pop(v);
      checks++;
      if ($signed(v) !== 12 + k) begin
        failures++;
        $display("[TB] FAIL full_drain%0d got=%0d exp=%0d", k, $signed(v), 12 + k);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_empty got=%b exp=1", fifo_empty);
    end
  endtask

  task automatic test_back_to_back_gaps();
    logic [7:0] v;
    bit seen;
    do_reset();
    d_in = {8'd4, 8'd3, 8'd2, 8'd1};
    start_job(8'd2, 4'd0, 8'd1, 8'd2, 16'd0, 16'd5);
    for (int c = 0; c < 4; c++) begin
      d_valid = c[0];
      if (c == 1) begin
        set_job(8'd7, 4'd3, 8'd9, 8'd9, 16'd100, 16'd100);
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      d_valid = 1'b0;
    end
    wait_done(10, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL gaps_done got=0 exp=1");
    end
    tick();
    pop(v);
    checks++;
    if ($signed(v) !== 20) begin
      failures++;
      $display("[TB] FAIL gaps_r0 got=%0d exp=20", $signed(v));
    end
    pop(v);
    checks++;
    if ($signed(v) !== 45) begin
      failures++;
      $display("[TB] FAIL gaps_r1 got=%0d exp=45", $signed(v));
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] v;
    bit seen;
    do_reset();
    for (int j = 0; j < 2; j++) begin
      start_job(8'd0, 4'd0, 8'd0, 8'd0, 16'd1, 16'd2);
      wait_done(10, seen);
      tick();
    end
    pop(v);
    start_job(8'd2, 4'd0, 8'd1, 8'd1, 16'd0, 16'd0);
    d_in = 32'h01010101;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    checks++;
    if ($signed(v) !== 1 || fifo_count !== 4'd3 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_pre got dout=%0d count=%0d busy=%b exp 1/3/1", $signed(v), fifo_count, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, d_ready, fifo_full, fifo_empty} !== 5'b00001 || d_out !== 8'd0 || fifo_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset got flags=%b dout=%0d count=%0d exp 00001/0/0",
               {busy, done, d_ready, fifo_full, fifo_empty}, d_out, fifo_count);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate_shift();
    test_len_zero();
    test_fifo_full();
    test_back_to_back_gaps();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
